// File: rtl/jpeg_mcu_block_sched.sv
// Multi-channel 8x8 block scheduler: ping-pong buffers raster pixel vectors and
// replays each block channel by channel, level-shifted, under valid/ready.
module jpeg_mcu_block_sched #(
  parameter int NUM_CH      = 3,
  parameter int DATA_W      = 8,
  parameter int LEVEL_SHIFT = 1
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [1:0]               out_ch,
  output logic                     out_is_luma,
  output logic                     out_first,
  output logic                     out_last,
  output logic [15:0]              blocks_done
);

  // state  | meaning
  // IDLE   | no block being replayed; waiting for full[rd_bank]
  // STREAM | output registers hold a valid sample of bank rd_bank

  localparam int DEPTH = 2 * NUM_CH * 64;
  localparam int AW    = $clog2(DEPTH);
  localparam logic [1:0]        LAST_CH    = 2'(NUM_CH - 1);
  localparam logic [DATA_W-1:0] MSB        = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] SHIFT_MASK = (LEVEL_SHIFT != 0) ? MSB : '0;

  typedef enum logic {IDLE, STREAM} state_t;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [1:0]        full, full_set, full_clr;
  logic              wr_bank, rd_bank, rd_bank_nxt;
  logic [5:0]        widx, rd_idx, idx_nxt;
  logic [1:0]        ch_nxt;
  logic              accept, wr_done;
  logic              valid_nxt, bank_release, load;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] data_nxt;
  state_t            state, state_nxt;

  function automatic logic [AW-1:0] addr_of(input logic bank, input logic [1:0] ch,
                                            input logic [5:0] idx);
    int a;
    a = ((bank ? NUM_CH : 0) + int'(ch)) * 64 + int'(idx);
    return a[AW-1:0];
  endfunction

  assign in_ready = !full[wr_bank];
  assign accept   = in_valid && in_ready;
  assign wr_done  = accept && (widx == 6'd63);
  assign full_set = wr_done ? (wr_bank ? 2'b10 : 2'b01) : 2'b00;
  assign full_clr = bank_release ? (rd_bank ? 2'b10 : 2'b01) : 2'b00;

  // Sample storage needs no reset: full flags gate every read.
  always_ff @(posedge clock) begin
    if (accept) begin
      for (int c = 0; c < NUM_CH; c++) begin
        mem[addr_of(wr_bank, c[1:0], widx)] <= in_data[c*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_bank <= 1'b0;
      widx    <= '0;
      full    <= '0;
    end else if (flush) begin
      wr_bank <= 1'b0;
      widx    <= '0;
      full    <= '0;
    end else begin
      if (accept) widx <= widx + 6'd1;
      if (wr_done) wr_bank <= !wr_bank;
      full <= (full | full_set) & ~full_clr;
    end
  end

  always_comb begin
    state_nxt    = state;
    rd_bank_nxt  = rd_bank;
    ch_nxt       = out_ch;
    idx_nxt      = rd_idx;
    valid_nxt    = out_valid;
    bank_release = 1'b0;
    load         = 1'b0;
    rd_addr      = '0;
    unique case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          state_nxt = STREAM;
          valid_nxt = 1'b1;
          ch_nxt    = 2'd0;
          idx_nxt   = 6'd0;
          load      = 1'b1;
          rd_addr   = addr_of(rd_bank, 2'd0, 6'd0);
        end
      end
      STREAM: begin
        if (out_valid && out_ready) begin
          if (rd_idx != 6'd63) begin
            idx_nxt = rd_idx + 6'd1;
            load    = 1'b1;
            rd_addr = addr_of(rd_bank, out_ch, idx_nxt);
          end else if (out_ch != LAST_CH) begin
            ch_nxt  = out_ch + 2'd1;
            idx_nxt = 6'd0;
            load    = 1'b1;
            rd_addr = addr_of(rd_bank, ch_nxt, 6'd0);
          end else begin
            bank_release = 1'b1;
            rd_bank_nxt  = !rd_bank;
            ch_nxt       = 2'd0;
            idx_nxt      = 6'd0;
            // Chain straight into the other bank when it is already waiting.
            if (full[!rd_bank]) begin
              load    = 1'b1;
              rd_addr = addr_of(!rd_bank, 2'd0, 6'd0);
            end else begin
              state_nxt = IDLE;
              valid_nxt = 1'b0;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    data_nxt = load ? (mem[rd_addr] ^ SHIFT_MASK) : out_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      rd_idx      <= '0;
      blocks_done <= '0;
    end else if (flush) begin
      state       <= IDLE;
      rd_bank     <= 1'b0;
      out_valid   <= 1'b0;
      out_data    <= '0;
      out_ch      <= '0;
      rd_idx      <= '0;
      blocks_done <= '0;
    end else begin
      state     <= state_nxt;
      rd_bank   <= rd_bank_nxt;
      out_valid <= valid_nxt;
      out_data  <= data_nxt;
      out_ch    <= ch_nxt;
      rd_idx    <= idx_nxt;
      if (bank_release) blocks_done <= blocks_done + 16'd1;
    end
  end

  // Flags are qualified by out_valid so an idle scheduler drives all zeros.
  assign out_is_luma = out_valid && (out_ch == 2'd0);
  assign out_first   = out_valid && (rd_idx == 6'd0);
  assign out_last    = out_valid && (rd_idx == 6'd63);

endmodule

// File: doc/jpeg_mcu_block_sched.md
Name: jpeg_mcu_block_sched

Overview:
- Parametrised multi-channel 8x8 block scheduler. It sits between the colour-conversion stage and a single shared per-block encoder core, replacing the luma-only path.
- It collects raster-ordered pixel vectors (one sample per channel per beat) into ping-pong block buffers.
- It replays each buffered block channel-by-channel (ch0 all 64 samples, then ch1, and so on), with a luminance flag, level-shifted and under valid/ready flow control.

Parameters:
- NUM_CH, 3, number of colour channels per pixel vector (ch0 = luminance); range 1..4.
- DATA_W, 8, bits per sample.
- LEVEL_SHIFT, 1, 1 = output sample minus 2^(DATA_W-1) (two's complement); 0 = pass through unchanged.

Ports:
- clock  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of both banks and the read FSM.
- in_valid  in  1  input pixel vector valid.
- in_ready  out  1  scheduler can accept a vector.
- in_data  in  NUM_CH*DATA_W  pixel vector; ch k occupies bits [k*DATA_W +: DATA_W].
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accepts the sample.
- out_data  out  DATA_W  sample (signed when LEVEL_SHIFT=1).
- out_ch  out  2  channel index of the current sample.
- out_is_luma  out  1  high when out_ch==0.
- out_first  out  1  sample index 0 of a channel block.
- out_last  out  1  sample index 63 of a channel block.
- blocks_done  out  16  count of completed MCUs (all channels emitted); wraps.

Behaviour:
- Reset and flush values: all outputs are 0, except in_ready=1. Both bank full flags are 0, wr_bank=0, rd_bank=0, write index=0, FSM=IDLE. Flush takes priority over every other event in the same cycle.
- Storage: two banks, each NUM_CH x 64 x DATA_W.
- Write side:
  - A beat is accepted when in_valid && in_ready.
  - The accepted beat stores each channel at [wr_bank][ch][widx]; widx increments.
  - On the accept with widx==63: full[wr_bank] is set, wr_bank toggles, widx wraps to 0.
  - in_ready = !full[wr_bank].
- Read FSM states:
  - IDLE: if full[rd_bank], go to STREAM. Load sample (ch0, idx0) into the output registers and set out_valid=1.
  - STREAM: on out_valid && out_ready, advance idx. On idx 63, advance ch. On ch NUM_CH-1 / idx 63:
    - clear full[rd_bank], toggle rd_bank, increment blocks_done;
    - if the other bank is already full, load its (ch0, idx0) in the same cycle with no bubble; otherwise go to IDLE with out_valid=0.
- Latency: the 64th input accept at edge k sets full. out_valid is high from edge k+1 (one-cycle fill-to-output latency).
- Throughput: one sample per cycle while out_ready=1. One MCU = NUM_CH*64 output beats.
- Handshake rules:
  - While out_valid && !out_ready, out_data, out_ch, out_first and out_last hold stable.
  - out_valid never drops without a handshake, except on flush or reset.
  - The input side never drops data; backpressure is via in_ready only.
- Flags:
  - out_first = (idx==0).
  - out_last = (idx==63).
  - out_is_luma = (out_ch==0).
- Arithmetic: with LEVEL_SHIFT=1, out_data = sample XOR MSB (equivalent to sample - 2^(DATA_W-1), modulo 2^DATA_W). 0 maps to 0x80 (-128) and 255 maps to 0x7F for DATA_W=8.
- Simultaneous events:
  - Write completing one bank and read releasing the other bank in the same cycle is legal and independent.
  - The same bank can never be set and cleared in the same cycle.
  - Both banks full gives in_ready=0 until read releases a bank. in_ready rises on the edge after the release.
- Reset mid-operation: asynchronous clear of everything. A partially written block is discarded.
- blocks_done wraps from 0xFFFF to 0.

Test Plan:
- Reset: assert reset_n=0 mid-stream → out_valid=0, in_ready=1, blocks_done=0 immediately. After release, the first 64 accepted vectors produce a full MCU.
- Single MCU, NUM_CH=3, ch0=i, ch1=i+64, ch2=255-i, out_ready=1 → out_valid one edge after the 64th accept. Then 192 beats: 0x80..0xBF with out_is_luma=1, then 0xC0..0xFF (ch1), then 0x7F..0x40 (ch2). first/last flags at indices 0/63; blocks_done=1.
- Backpressure: out_ready toggles 1/0 randomly → out_data and out_ch stable during stalls; the sequence matches the single-MCU case; no duplicated or dropped samples.
- Ping-pong: feed 3 MCUs back-to-back with out_ready=1 → in_ready=0 once both banks are full. MCU2 starts with no bubble after the last beat of MCU1; blocks_done=3.
- Flush: assert after 30 output beats with bank B half written → next cycle out_valid=0, in_ready=1. A fresh 64-vector block emits starting at (ch0, idx0).
- LEVEL_SHIFT=0, NUM_CH=1, DATA_W=12: input 0xFFF → out 0xFFF; 64 beats per MCU; out_ch=0 throughout.
